// File: rtl/multicycle_datapath_pkg.sv
// Shared types and constants for the multi-cycle datapath: FSM states, ALU encodings
// and the fixed 16-bit instruction field layout.
package datapath_pkg;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        ALU_ADD   = 2'b00,
        ALU_SUB   = 2'b01,
        ALU_RTYPE = 2'b10,
        ALU_ORI   = 2'b11
    } aluop_e;

    typedef enum logic [1:0] {
        FN_ADD = 2'b00,
        FN_SUB = 2'b01,
        FN_AND = 2'b10,
        FN_OR  = 2'b11
    } funct_e;

    localparam logic [3:0]  OPC_HALT = 4'hF;

    localparam int unsigned INSTR_W  = 16;
    localparam int unsigned NREGS    = 4;
    localparam int unsigned REG_AW   = 2;
    localparam int unsigned IMM_W    = 8;

    localparam int unsigned OPC_MSB  = 15;
    localparam int unsigned OPC_LSB  = 12;
    localparam int unsigned RS_MSB   = 11;
    localparam int unsigned RS_LSB   = 10;
    localparam int unsigned RT_MSB   = 9;
    localparam int unsigned RT_LSB   = 8;
    localparam int unsigned RD_MSB   = 7;
    localparam int unsigned RD_LSB   = 6;
    localparam int unsigned FN_MSB   = 1;
    localparam int unsigned FN_LSB   = 0;
    localparam int unsigned IMM_MSB  = 7;
    localparam int unsigned IMM_LSB  = 0;

endpackage

// File: rtl/dp_alu.sv
// Combinational ALU for the multi-cycle datapath: second-operand select, ALU-class /
// funct decode and the equality flag used by BEQ.
module dp_alu
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic [DATA_W-1:0] imm_i,
    input  logic              alu_src_i,
    input  logic [1:0]        alu_op_i,
    input  logic [1:0]        funct_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o
);

    logic [DATA_W-1:0] op2;
    logic [DATA_W-1:0] diff;

    always_comb begin
        op2      = alu_src_i ? imm_i : b_i;
        diff     = a_i - op2;
        zero_o   = (diff == '0);
        result_o = '0;
        case (aluop_e'(alu_op_i))
            ALU_ADD: result_o = a_i + op2;
            ALU_SUB: result_o = diff;
            ALU_RTYPE: begin
                case (funct_e'(funct_i))
                    FN_ADD:  result_o = a_i + op2;
                    FN_SUB:  result_o = diff;
                    FN_AND:  result_o = a_i & op2;
                    FN_OR:   result_o = a_i | op2;
                    default: result_o = '0;
                endcase
            end
            ALU_ORI: result_o = a_i | op2;
            default: result_o = '0;
        endcase
    end

endmodule

// File: rtl/multicycle_datapath.sv
// Width-generic multi-cycle datapath sequenced by FETCH/DECODE/EXEC/MEM/WB with
// req/ready handshakes to external instruction and data memories.
module multicycle_datapath
    import datapath_pkg::*;
#(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned RESET_PC = 10,
    parameter int unsigned PC_INC   = 2
) (
    input  logic                Clock,
    input  logic                Reset_n,
    input  logic                RegDst,
    input  logic                Branch,
    input  logic                MemRead,
    input  logic                MemWrite,
    input  logic                RegWrite,
    input  logic                MemToReg,
    input  logic                ALUSrc,
    input  logic [1:0]          ALUOp,
    output logic [3:0]          opcode,
    output logic                imem_req,
    output logic [DATA_W-1:0]   imem_addr,
    input  logic                imem_ready,
    input  logic [INSTR_W-1:0]  imem_rdata,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic [DATA_W-1:0]   dmem_addr,
    output logic [DATA_W-1:0]   dmem_wdata,
    input  logic                dmem_ready,
    input  logic [DATA_W-1:0]   dmem_rdata,
    output logic                halted,
    output logic [DATA_W-1:0]   pc
);

    localparam logic [DATA_W-1:0] PC_RST  = DATA_W'(RESET_PC);
    localparam logic [DATA_W-1:0] PC_STEP = DATA_W'(PC_INC);

    state_e               state_q;
    logic [DATA_W-1:0]    pc_q;
    logic [INSTR_W-1:0]   ir_q;
    logic [DATA_W-1:0]    a_q;
    logic [DATA_W-1:0]    b_q;
    logic [DATA_W-1:0]    aluout_q;
    logic [DATA_W-1:0]    mdr_q;
    logic [DATA_W-1:0]    regs_q [NREGS];
    logic                 imem_req_q;
    logic                 dmem_req_q;
    logic                 dmem_we_q;
    logic                 halted_q;

    logic [REG_AW-1:0]    rs;
    logic [REG_AW-1:0]    rt;
    logic [REG_AW-1:0]    rd;
    logic [1:0]           funct;
    logic [DATA_W-1:0]    imm_ext;
    logic [DATA_W-1:0]    br_off;
    logic [REG_AW-1:0]    wb_idx_d;
    logic [DATA_W-1:0]    wb_data_d;
    logic [DATA_W-1:0]    alu_res_d;
    logic                 alu_zero_d;

    always_comb begin
        rs        = ir_q[RS_MSB:RS_LSB];
        rt        = ir_q[RT_MSB:RT_LSB];
        rd        = ir_q[RD_MSB:RD_LSB];
        funct     = ir_q[FN_MSB:FN_LSB];
        imm_ext   = {{(DATA_W-IMM_W){ir_q[IMM_MSB]}}, ir_q[IMM_MSB:IMM_LSB]};
        br_off    = {imm_ext[DATA_W-2:0], 1'b0};
        wb_idx_d  = RegDst ? rd : rt;
        wb_data_d = MemToReg ? mdr_q : aluout_q;
    end

    dp_alu #(
        .DATA_W (DATA_W)
    ) u_alu (
        .a_i       (a_q),
        .b_i       (b_q),
        .imm_i     (imm_ext),
        .alu_src_i (ALUSrc),
        .alu_op_i  (ALUOp),
        .funct_i   (funct),
        .result_o  (alu_res_d),
        .zero_o    (alu_zero_d)
    );

    // FETCH raises imem_req one cycle after reset, so a ready seen before the request is never taken.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q    <= S_FETCH;
            pc_q       <= PC_RST;
            ir_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            aluout_q   <= '0;
            mdr_q      <= '0;
            imem_req_q <= 1'b0;
            dmem_req_q <= 1'b0;
            dmem_we_q  <= 1'b0;
            halted_q   <= 1'b0;
            for (int unsigned i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (imem_req_q && imem_ready) begin
                        ir_q       <= imem_rdata;
                        pc_q       <= pc_q + PC_STEP;
                        imem_req_q <= 1'b0;
                        state_q    <= S_DECODE;
                    end else begin
                        imem_req_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    a_q <= regs_q[rs];
                    b_q <= regs_q[rt];
                    if (ir_q[OPC_MSB:OPC_LSB] == OPC_HALT) begin
                        halted_q <= 1'b1;
                        state_q  <= S_HALT;
                    end else begin
                        state_q  <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    aluout_q <= alu_res_d;
                    if (Branch) begin
                        if (alu_zero_d) begin
                            pc_q <= pc_q + br_off;
                        end
                        imem_req_q <= 1'b1;
                        state_q    <= S_FETCH;
                    end else if (MemRead || MemWrite) begin
                        dmem_req_q <= 1'b1;
                        dmem_we_q  <= MemWrite;
                        state_q    <= S_MEM;
                    end else begin
                        state_q    <= S_WB;
                    end
                end
                S_MEM: begin
                    if (dmem_req_q && dmem_ready) begin
                        dmem_req_q <= 1'b0;
                        dmem_we_q  <= 1'b0;
                        if (dmem_we_q) begin
                            imem_req_q <= 1'b1;
                            state_q    <= S_FETCH;
                        end else begin
                            mdr_q   <= dmem_rdata;
                            state_q <= S_WB;
                        end
                    end
                end
                S_WB: begin
                    if (RegWrite) begin
                        regs_q[wb_idx_d] <= wb_data_d;
                    end
                    imem_req_q <= 1'b1;
                    state_q    <= S_FETCH;
                end
                S_HALT: begin
                    halted_q   <= 1'b1;
                    imem_req_q <= 1'b0;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                end
                default: begin
                    imem_req_q <= 1'b0;
                    state_q    <= S_FETCH;
                end
            endcase
        end
    end

    assign opcode     = ir_q[OPC_MSB:OPC_LSB];
    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = aluout_q;
    assign dmem_wdata = b_q;
    assign halted     = halted_q;
    assign pc         = pc_q;

endmodule
